// File: rtl/mem_port_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way memory port round-robin arbiter.
package mem_port_rr_arbiter_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mem_port_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, .. ptr+3.
module rr_pick4
   import mem_port_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // scan from farthest to nearest so the nearest hit to ptr is the one kept
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin owner of a shared 32-bit memory port: drives the mux select and
// sequences mem_req/mem_ack with lock and per-transaction timeout.
//
//  state | meaning
//  IDLE  | no transaction outstanding, mem_req low, grant zero
//  BUSY  | owner sel has a transaction outstanding, waiting for mem_ack
module mem_port_rr_arbiter
   import mem_port_rr_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] lock,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] ack,
   output logic [N_REQ-1:0] err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state, state_nxt;
   logic [SEL_W-1:0] sel_nxt, ptr, ptr_nxt;
   logic [N_REQ-1:0] grant_nxt, err_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [N_REQ-1:0] pick_req;
   logic [SEL_W-1:0] pick_ptr;
   logic             pick_valid;
   logic [SEL_W-1:0] pick_idx;
   logic             timeout;

   // while busy, the current owner is masked and the scan starts just past it
   assign pick_req = (state == BUSY) ? (req & ~onehot(sel)) : req;
   assign pick_ptr = (state == BUSY) ? (sel + SEL_W'(1)) : ptr;

   rr_pick4 u_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign timeout = (TIMEOUT_CYCLES != 0) && (state == BUSY) && (cnt == TO_LAST) && !mem_ack;
   assign busy    = (state == BUSY);
   assign mem_req = (state == BUSY);
   assign ack     = {N_REQ{mem_ack & busy}} & onehot(sel);

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      err_nxt   = '0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt = BUSY;
               sel_nxt   = pick_idx;
               grant_nxt = onehot(pick_idx);
               cnt_nxt   = '0;
            end
         end
         BUSY: begin
            if (mem_ack || timeout) begin
               ptr_nxt = sel + SEL_W'(1);
               cnt_nxt = '0;
               if (timeout) err_nxt = onehot(sel);
               // lock only holds the port on a real completion, never on abort
               if (mem_ack && lock[sel] && req[sel]) begin
                  sel_nxt = sel;
               end else if (pick_valid) begin
                  sel_nxt   = pick_idx;
                  grant_nxt = onehot(pick_idx);
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sel   <= '0;
         grant <= '0;
         err   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         grant <= grant_nxt;
         err   <= err_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Directed bench for mem_port_rr_arbiter with a queue of expected grant owners.
module tb_mem_port_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] lock;
   logic       mem_ack;
   logic       mem_req;
   logic [1:0] sel;
   logic [3:0] grant;
   logic [3:0] ack;
   logic [3:0] err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   mem_port_rr_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .lock    (lock),
      .mem_ack (mem_ack),
      .mem_req (mem_req),
      .sel     (sel),
      .grant   (grant),
      .ack     (ack),
      .err     (err),
      .busy    (busy)
   );

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_grant(input string tag);
      int e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_underflow"}, 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_sel"}, 32'(sel), 32'(e));
         check({tag, "_grant"}, 32'(grant), 32'(oh(e)));
         check({tag, "_mem_req"}, 32'(mem_req), 1);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      req     = '0;
      lock    = '0;
      mem_ack = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      settle();
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_sel", 32'(sel), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      mem_ack = 1'b1;
      settle();
      check("idle_ack_ignored", 32'(ack), 0);
      cyc();
      mem_ack = 1'b0;
      settle();
      check("idle_stays", 32'(busy), 0);

      // single request, ack on third busy cycle
      req = 4'b0100;
      exp_q.push_back(2);
      cyc();
      settle();
      chk_grant("t1_grant");
      cyc();
      cyc();
      mem_ack = 1'b1;
      settle();
      check("t1_ack", 32'(ack), 32'h4);
      check("t1_no_err", 32'(err), 0);
      cyc();
      mem_ack = 1'b0;
      req     = '0;
      settle();
      check("t1_idle_mem_req", 32'(mem_req), 0);
      check("t1_idle_grant", 32'(grant), 0);
      check("t1_idle_ack", 32'(ack), 0);

      // all requesting: rotate 0,1,2,3,0 with no bubble
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
      cyc();
      settle();
      for (int k = 0; k < 5; k++) begin
         chk_grant("t2_grant");
         cyc();
         check("t2_no_bubble", 32'(mem_req), 1);
         mem_ack = 1'b1;
         settle();
         check("t2_ack", 32'(ack), 32'(oh(k % 4)));
         cyc();
         mem_ack = 1'b0;
         settle();
      end

      // lock keeps requester 0, unlock rotates to 1
      do_reset();
      req  = 4'b0011;
      lock = 4'b0001;
      exp_q.push_back(0);
      cyc();
      settle();
      chk_grant("t3_first");
      for (int k = 0; k < 3; k++) begin
         mem_ack = 1'b1;
         settle();
         check("t3_ack", 32'(ack), 32'h1);
         exp_q.push_back(0);
         cyc();
         mem_ack = 1'b0;
         settle();
         chk_grant("t3_locked");
      end
      lock    = '0;
      mem_ack = 1'b1;
      settle();
      check("t3_ack_unlock", 32'(ack), 32'h1);
      exp_q.push_back(1);
      cyc();
      mem_ack = 1'b0;
      settle();
      chk_grant("t3_unlock");

      // timeout with nobody else waiting: err pulse then idle
      do_reset();
      req = 4'b1000;
      exp_q.push_back(3);
      cyc();
      settle();
      chk_grant("t4_grant");
      for (int k = 0; k < 2; k++) begin
         cyc();
         settle();
         check("t4_wait_err", 32'(err), 0);
         check("t4_wait_busy", 32'(busy), 1);
      end
      cyc();
      settle();
      check("t4_last_err", 32'(err), 0);
      check("t4_last_ack", 32'(ack), 0);
      cyc();
      settle();
      check("t4_err", 32'(err), 32'h8);
      check("t4_err_ack", 32'(ack), 0);
      check("t4_idle_busy", 32'(busy), 0);
      check("t4_idle_grant", 32'(grant), 0);
      req = '0;
      cyc();
      settle();
      check("t4_err_pulse", 32'(err), 0);

      // timeout with requester 0 waiting: rearbitrate to 0 without bubble
      do_reset();
      req = 4'b1000;
      exp_q.push_back(3);
      cyc();
      settle();
      chk_grant("t4b_grant");
      req = 4'b1001;
      cyc();
      cyc();
      cyc();
      settle();
      check("t4b_pre_err", 32'(err), 0);
      exp_q.push_back(0);
      cyc();
      settle();
      check("t4b_err", 32'(err), 32'h8);
      check("t4b_ack", 32'(ack), 0);
      chk_grant("t4b_rearb");
      cyc();
      settle();
      check("t4b_err_pulse", 32'(err), 0);

      // lone requester: masked for one idle cycle; ack beats timeout
      do_reset();
      req = 4'b0100;
      exp_q.push_back(2);
      cyc();
      settle();
      chk_grant("t5_grant");
      mem_ack = 1'b1;
      settle();
      check("t5_ack", 32'(ack), 32'h4);
      cyc();
      mem_ack = 1'b0;
      settle();
      check("t5_idle_busy", 32'(busy), 0);
      check("t5_idle_grant", 32'(grant), 0);
      exp_q.push_back(2);
      cyc();
      settle();
      chk_grant("t5_regrant");
      cyc();
      cyc();
      cyc();
      mem_ack = 1'b1;
      settle();
      check("t5_to_ack", 32'(ack), 32'h4);
      check("t5_to_err", 32'(err), 0);
      cyc();
      mem_ack = 1'b0;
      settle();
      check("t5_no_err", 32'(err), 0);
      check("t5_after_busy", 32'(busy), 0);

      // reset while requester 3 owns the port; ptr must return to 0
      do_reset();
      req = 4'b0010;
      exp_q.push_back(1);
      cyc();
      settle();
      chk_grant("t6_own1");
      req     = 4'b1010;
      mem_ack = 1'b1;
      exp_q.push_back(3);
      cyc();
      mem_ack = 1'b0;
      req     = 4'b1000;
      settle();
      chk_grant("t6_own3");
      reset   = 1'b1;
      mem_ack = 1'b1;
      cyc();
      settle();
      check("t6_rst_mem_req", 32'(mem_req), 0);
      check("t6_rst_sel", 32'(sel), 0);
      check("t6_rst_grant", 32'(grant), 0);
      check("t6_rst_err", 32'(err), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_ack", 32'(ack), 0);
      reset   = 1'b0;
      mem_ack = 1'b0;
      req     = 4'b1111;
      exp_q.push_back(0);
      cyc();
      settle();
      chk_grant("t6_ptr0");

      check("sb_drain", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
